// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: opcodes, instruction field positions, FSM states, immediate helper.
// Pure declarations; no latency and no flow control of its own.
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam int OP_LSB   = 13;
  localparam int RA_LSB   = 10;
  localparam int RB_LSB   = 7;
  localparam int RC_LSB   = 0;
  localparam int IMM7_LSB = 0;
  localparam int IMM10_LSB = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/risc16_regfile.sv
// 8 x 16 register file, r0 reads zero; three combinational read ports, one write port.
// Writes land on the clock edge and are visible next cycle; never stalls.
module risc16_regfile
  import risc16_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_ra_addr,
  input  logic [2:0]  i_rb_addr,
  input  logic [2:0]  i_rc_addr,
  input  logic        i_we,
  input  logic [2:0]  i_wa,
  input  logic [15:0] i_wd,
  output logic [15:0] o_ra,
  output logic [15:0] o_rb,
  output logic [15:0] o_rc
);

  // r0 has no storage at all, so it can never hold anything but zero.
  logic [15:0] r_regs [1:7];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < 8; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 3'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_ra = (i_ra_addr == 3'd0) ? 16'h0000 : r_regs[i_ra_addr];
  assign o_rb = (i_rb_addr == 3'd0) ? 16'h0000 : r_regs[i_rb_addr];
  assign o_rc = (i_rc_addr == 3'd0) ? 16'h0000 : r_regs[i_rc_addr];

endmodule

// File: rtl/risc16_core.sv
// Multi-cycle RiSC-16 core with req/ack instruction and data ports, halt state and retire pulse.
// 2 cycles per ALU/branch/jump, 3 per load/store, +1 per memory wait cycle; holds request until ack.
module risc16_core
  import risc16_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic [15:0]     dmem_wdata,
  input  logic            dmem_ack,
  input  logic [15:0]     dmem_rdata,
  output logic            retire,
  output logic            halted,
  output logic [PC_W-1:0] dbg_pc
);

  state_t          r_state, w_state_nxt;
  logic            r_run;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [15:0]     r_ir;
  logic [PC_W-1:0] r_dmem_addr;
  logic [15:0]     r_dmem_wdata;
  logic            r_dmem_we;

  logic [2:0]      w_op, w_ra, w_rb, w_rc;
  logic [15:0]     w_simm, w_ra_val, w_rb_val, w_rc_val;
  logic [9:0]      w_imm10;
  logic            w_is_halt, w_imem_fire, w_dmem_fire;
  logic [PC_W-1:0] w_pc_inc, w_br_tgt, w_ea;
  logic            w_rf_we, w_mem_start, w_retire;
  logic [15:0]     w_rf_wd;

  assign w_op      = r_ir[OP_LSB +: 3];
  assign w_ra      = r_ir[RA_LSB +: 3];
  assign w_rb      = r_ir[RB_LSB +: 3];
  assign w_rc      = r_ir[RC_LSB +: 3];
  assign w_simm    = sext7(r_ir[IMM7_LSB +: 7]);
  assign w_imm10   = r_ir[IMM10_LSB +: 10];
  assign w_is_halt = (w_op == OP_JALR) && (r_ir[IMM7_LSB +: 7] != 7'd0);

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_br_tgt = w_pc_inc + w_simm[PC_W-1:0];
  assign w_ea     = PC_W'(w_rb_val + w_simm);

  // r_run keeps fetch quiet while reset is held and releases it on the first clock after.
  assign imem_req    = (r_state == FETCH) && r_run;
  assign imem_addr   = r_pc;
  assign w_imem_fire = imem_req && imem_ack;

  assign dmem_req    = (r_state == MEM);
  assign dmem_we     = r_dmem_we && dmem_req;
  assign dmem_addr   = r_dmem_addr;
  assign dmem_wdata  = r_dmem_wdata;
  assign w_dmem_fire = dmem_req && dmem_ack;

  assign retire = w_retire;
  assign halted = (r_state == HALT);
  assign dbg_pc = r_pc;

  risc16_regfile u_regfile (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ra_addr (w_ra),
    .i_rb_addr (w_rb),
    .i_rc_addr (w_rc),
    .i_we      (w_rf_we),
    .i_wa      (w_ra),
    .i_wd      (w_rf_wd),
    .o_ra      (w_ra_val),
    .o_rb      (w_rb_val),
    .o_rc      (w_rc_val)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rf_we     = 1'b0;
    w_rf_wd     = 16'h0000;
    w_mem_start = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_imem_fire) w_state_nxt = EXEC;
      end
      EXEC: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = w_pc_inc;
        w_retire    = 1'b1;
        case (w_op)
          OP_ADD: begin
            w_rf_we = 1'b1;
            w_rf_wd = w_rb_val + w_rc_val;
          end
          OP_ADDI: begin
            w_rf_we = 1'b1;
            w_rf_wd = w_rb_val + w_simm;
          end
          OP_NAND: begin
            w_rf_we = 1'b1;
            w_rf_wd = ~(w_rb_val & w_rc_val);
          end
          OP_LUI: begin
            w_rf_we = 1'b1;
            w_rf_wd = {w_imm10, 6'b000000};
          end
          OP_SW, OP_LW: begin
            w_mem_start = 1'b1;
            w_state_nxt = MEM;
            w_pc_nxt    = r_pc;
            w_retire    = 1'b0;
          end
          OP_BEQ: begin
            if (w_ra_val == w_rb_val) w_pc_nxt = w_br_tgt;
          end
          OP_JALR: begin
            if (w_is_halt) begin
              w_state_nxt = HALT;
              w_pc_nxt    = r_pc;
              w_retire    = 1'b0;
            end else begin
              w_rf_we  = 1'b1;
              w_rf_wd  = 16'(w_pc_inc);
              w_pc_nxt = w_rb_val[PC_W-1:0];
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        if (w_dmem_fire) begin
          w_rf_we     = !r_dmem_we;
          w_rf_wd     = dmem_rdata;
          w_pc_nxt    = w_pc_inc;
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      HALT: ;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_pc         <= PC_W'(RESET_PC);
      r_ir         <= 16'h0000;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= 16'h0000;
      r_dmem_we    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_pc  <= w_pc_nxt;
      if (w_imem_fire) r_ir <= imem_rdata;
      // Address, data and direction are frozen here so they stay stable through any wait states.
      if (w_mem_start) begin
        r_dmem_addr  <= w_ea;
        r_dmem_wdata <= w_ra_val;
        r_dmem_we    <= (w_op == OP_SW);
      end
    end
  end

endmodule

// File: tb/tb_risc16_core.sv
// Directed bench for risc16_core: zero/wait-state memory models, hand-computed expectations.
module tb_risc16_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        retire, halted;
  logic [7:0]  dbg_pc;

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:255];
  logic        dmem_clr = 1'b0;
  int          imem_wait = 0;
  int          dmem_wait = 0;
  int          icnt = 0;
  int          dcnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          stab_err = 0;
  int          ret_q[$];
  int          fetch_q[$];
  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  localparam logic [15:0] NOP  = 16'h2000;
  localparam logic [15:0] HLT  = 16'hE001;

  risc16_core #(.PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .halted     (halted),
    .dbg_pc     (dbg_pc)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (icnt >= imem_wait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    cyc  <= rst_n ? cyc + 1 : 0;
    if (dmem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 16'hD000 | 16'(i);
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ret_q.delete();
      fetch_q.delete();
    end else begin
      if (retire) ret_q.push_back(cyc);
      if (imem_req && imem_ack) fetch_q.push_back(int'(imem_addr));
      if (dmem_req && prev_req &&
          (dmem_addr != prev_addr || dmem_wdata != prev_wdata || dmem_we != prev_we))
        stab_err++;
    end
    prev_req   <= dmem_req;
    prev_addr  <= dmem_addr;
    prev_wdata <= dmem_wdata;
    prev_we    <= dmem_we;
  end

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [6:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [15:0] rreg(input int i);
    return dut.u_regfile.r_regs[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    dmem_clr = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = HLT;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    dmem_clr = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int busy, nz;

    // Reset state
    start_reset();
    @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_dmem_addr", {24'd0, dmem_addr}, 32'd0);
    check("rst_dmem_wdata", {16'd0, dmem_wdata}, 32'd0);
    check("rst_retire_halted", {30'd0, retire, halted}, 32'd0);
    check("rst_pc", {24'd0, dbg_pc}, 32'd0);

    // LUI/ADDI build 0x1234, r0 write discarded, r0 stored as 0
    imem[0] = {3'b011, 3'd1, 10'h048};
    imem[1] = rri(3'b001, 3'd1, 3'd1, 7'h34);
    imem[2] = rri(3'b001, 3'd0, 3'd0, 7'd5);
    imem[3] = rri(3'b100, 3'd0, 3'd0, 7'd5);
    release_reset();
    @(negedge clk);
    check("first_fetch_req", {31'd0, imem_req}, 32'd1);
    wait_halt("s1_halt", 100);
    check("s1_ret0", ret_q.size() > 0 ? ret_q[0] : -1, 32'd2);
    check("s1_ret1", ret_q.size() > 1 ? ret_q[1] : -1, 32'd4);
    check("s1_ret_count", ret_q.size(), 32'd4);
    check("s1_r1", {16'd0, rreg(1)}, 32'h1234);
    check("s1_r0_stored", {16'd0, dmem[5]}, 32'd0);
    check("s1_halt_pc", {24'd0, dbg_pc}, 32'd4);

    // Halt is sticky and silent
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire || !halted) busy++;
    end
    check("halt_quiet", busy, 32'd0);
    check("halt_r1_kept", {16'd0, rreg(1)}, 32'h1234);

    // SW then LW with 3 data wait states
    start_reset();
    dmem_wait = 3;
    imem[0] = {3'b011, 3'd1, 10'h048};
    imem[1] = rri(3'b001, 3'd1, 3'd1, 7'h34);
    imem[2] = rri(3'b100, 3'd1, 3'd0, 7'd10);
    imem[3] = rri(3'b101, 3'd2, 3'd0, 7'd10);
    release_reset();
    busy = 0;
    while (!dmem_req && busy < 50) begin
      @(negedge clk);
      busy++;
    end
    check("sw_addr", {24'd0, dmem_addr}, 32'd10);
    check("sw_wdata", {16'd0, dmem_wdata}, 32'h1234);
    check("sw_we", {31'd0, dmem_we}, 32'd1);
    wait_halt("s2_halt", 200);
    check("sw_cycles", ret_q.size() > 2 ? ret_q[2] - ret_q[1] : -1, 32'd6);
    check("lw_cycles", ret_q.size() > 3 ? ret_q[3] - ret_q[2] : -1, 32'd6);
    check("sw_mem", {16'd0, dmem[10]}, 32'h1234);
    check("lw_r2", {16'd0, rreg(2)}, 32'h1234);
    check("dmem_stable", stab_err, 32'd0);
    dmem_wait = 0;

    // BEQ taken skips the following instruction
    start_reset();
    for (int i = 0; i < 4; i++) imem[i] = NOP;
    imem[4] = rri(3'b110, 3'd0, 3'd0, 7'd2);
    imem[5] = rri(3'b001, 3'd5, 3'd0, 7'd1);
    imem[6] = rri(3'b001, 3'd5, 3'd0, 7'd2);
    release_reset();
    wait_halt("beq_t_halt", 100);
    check("beq_t_next", fetch_q.size() > 5 ? fetch_q[5] : -1, 32'd7);
    check("beq_t_fetches", fetch_q.size(), 32'd6);
    check("beq_t_r5", {16'd0, rreg(5)}, 32'd0);

    // BEQ not taken falls through
    start_reset();
    imem[0] = rri(3'b001, 3'd1, 3'd0, 7'd1);
    for (int i = 1; i < 4; i++) imem[i] = NOP;
    imem[4] = rri(3'b110, 3'd1, 3'd0, 7'd2);
    imem[5] = rri(3'b001, 3'd5, 3'd0, 7'd1);
    release_reset();
    wait_halt("beq_nt_halt", 100);
    check("beq_nt_next", fetch_q.size() > 5 ? fetch_q[5] : -1, 32'd5);
    check("beq_nt_r5", {16'd0, rreg(5)}, 32'd1);

    // JALR link and jump
    start_reset();
    imem[0] = rri(3'b001, 3'd3, 3'd0, 7'd20);
    for (int i = 1; i < 9; i++) imem[i] = NOP;
    imem[9] = rri(3'b111, 3'd4, 3'd3, 7'd0);
    release_reset();
    wait_halt("jalr_halt", 100);
    check("jalr_link", {16'd0, rreg(4)}, 32'h000A);
    check("jalr_next", fetch_q.size() > 10 ? fetch_q[10] : -1, 32'd20);
    check("jalr_pc", {24'd0, dbg_pc}, 32'd20);

    // BEQ simm=-1 at pc 0 loops on itself
    start_reset();
    imem[0] = rri(3'b110, 3'd0, 3'd0, 7'h7F);
    release_reset();
    repeat (30) @(negedge clk);
    nz = 0;
    foreach (fetch_q[i]) if (fetch_q[i] != 0) nz++;
    check("loop_fetches", {31'd0, fetch_q.size() >= 10}, 32'd1);
    check("loop_addr_zero", nz, 32'd0);
    check("loop_not_halted", {31'd0, halted}, 32'd0);

    // BEQ at pc 255 wraps to 0
    start_reset();
    imem[0] = rri(3'b110, 3'd6, 3'd0, 7'd1);
    imem[2] = rri(3'b001, 3'd6, 3'd0, 7'd1);
    imem[3] = {3'b011, 3'd3, 10'd3};
    imem[4] = rri(3'b001, 3'd3, 3'd3, 7'd63);
    imem[5] = rri(3'b111, 3'd0, 3'd3, 7'd0);
    imem[255] = rri(3'b110, 3'd0, 3'd0, 7'd0);
    release_reset();
    wait_halt("wrap_halt", 100);
    check("wrap_r3", {16'd0, rreg(3)}, 32'd255);
    check("wrap_at255", fetch_q.size() > 5 ? fetch_q[5] : -1, 32'd255);
    check("wrap_to0", fetch_q.size() > 6 ? fetch_q[6] : -1, 32'd0);
    check("wrap_halt_pc", {24'd0, dbg_pc}, 32'd1);

    // Reset during a pending store
    start_reset();
    dmem_wait = 50;
    imem[0] = rri(3'b001, 3'd1, 3'd0, 7'd7);
    imem[1] = rri(3'b100, 3'd1, 3'd0, 7'd10);
    release_reset();
    busy = 0;
    while (!dmem_req && busy < 50) begin
      @(negedge clk);
      busy++;
    end
    check("abort_req_seen", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_drop", {30'd0, dmem_req, imem_req}, 32'd0);
    nz = 0;
    for (int i = 1; i < 8; i++) if (rreg(i) != 16'h0000) nz++;
    check("abort_regs_zero", nz, 32'd0);
    check("abort_pc", {24'd0, dbg_pc}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_no_store", {16'd0, dmem[10]}, 32'hD00A);
    check("abort_pc_after", {24'd0, dbg_pc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc16_core.md
# risc16_core

Multi-cycle, parametrised RiSC-16 core. It fetches from and loads/stores to external instruction and data memories over req/ack handshakes, so it tolerates wait states. It replaces the single-cycle core's branch-delay-slot behaviour with clean sequential semantics and adds a halt state and retire/debug outputs. It is the CPU block that a memory/peripheral fabric sits behind.

## Interface
- PC_W, 8, instruction/data address width (8..16); PC and addresses wrap mod 2^PC_W
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous active-low
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  PC_W  data address
- dmem_wdata  out  16  store data
- dmem_ack  in  1  access complete; for loads, rdata valid this cycle
- dmem_rdata  in  16  load data
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped
- dbg_pc  out  PC_W  current pc

## Operation
- Instruction fields:
  - opcode = ir[15:13], rA = ir[12:10], rB = ir[9:7], rC = ir[2:0]
  - simm = sign-extend(ir[6:0]) to 16 bits; imm10 = ir[9:0]
- Opcodes:
  - 000 ADD: rA = rB + rC
  - 001 ADDI: rA = rB + simm
  - 010 NAND: rA = ~(rB & rC)
  - 011 LUI: rA = {imm10, 6'b0}
  - 100 SW: mem[rB + simm] = rA
  - 101 LW: rA = mem[rB + simm]
  - 110 BEQ: if rA == rB, pc = pc + 1 + simm
  - 111 JALR: rA = pc + 1 (zero-extended), then pc = rB[PC_W-1:0]
- JALR with ir[6:0] != 0 is HALT: no register write, pc unchanged, enter HALT.
- No delay slot. The instruction following a taken branch is never executed.
- Register file and arithmetic:
  - 8 x 16-bit registers; r0 reads 0 and writes to it are discarded.
  - Arithmetic is mod 2^16.
  - Data address = low PC_W bits of (rB + simm).
  - BEQ target and pc+1 are mod 2^PC_W.
- FSM states:
  - FETCH: imem_req = 1. On imem_ack, latch ir and go to EXEC.
  - EXEC, ALU/LUI/BEQ/JALR: write the register, update pc, pulse retire, go to FETCH.
  - EXEC, LW/SW: latch dmem_addr and dmem_wdata, go to MEM.
  - EXEC, HALT: go to HALT.
  - MEM: dmem_req = 1. On dmem_ack: LW writes rA from dmem_rdata, pc = pc + 1, pulse retire, go to FETCH.
  - HALT: all requests low, halted = 1. Only reset leaves HALT.
- Handshake rules:
  - While req is high, addr, we and wdata are held stable until the ack cycle.
  - req drops in the cycle after ack.
  - ack may be asserted in the same cycle req rises, including combinational ack.
  - ack while req is low is ignored.

## Timing
- Reset values:
  - state FETCH, pc = RESET_PC, all registers 0, ir 0
  - imem_req/dmem_req/dmem_we 0; dmem_addr/dmem_wdata 0
  - retire 0, halted 0
- imem_req first asserts in the first clk after rst_n deasserts.
- Latency with zero-wait ack:
  - ALU, LUI, BEQ, JALR: 2 cycles (FETCH, EXEC)
  - LW, SW: 3 cycles
  - Each memory wait cycle adds 1 cycle.
- retire is asserted in the final cycle of the instruction. The register write is visible from the next cycle.
- Reset asserted mid-handshake drops req asynchronously. The abandoned access must be tolerated by memory and is never retried.
- The stored value for SW is the rA value read in EXEC.

## Structure
- Package risc16_pkg holds:
  - opcode constants
  - state enum {FETCH, EXEC, MEM, HALT}
  - field position constants
  - sign-extension function
- Sub-module risc16_regfile:
  - 8 x 16, two asynchronous read ports plus an rA read port
  - one synchronous write port; r0 hardwired 0
  - async active-low reset clears all entries

## Test plan
- LUI r1,0x048; ADDI r1,r1,0x34 with zero-wait memories -> r1 = 0x1234; retire pulses at cycles 2 and 4; ADDI r0,r0,5 leaves r0 = 0.
- SW r1,r0,10 then LW r2,r0,10 with dmem_ack delayed 3 cycles -> dmem_addr/dmem_wdata stable during the wait; r2 = 0x1234; each access takes 6 cycles.
- BEQ r0,r0,2 at pc 4 -> next fetch address 7; instruction 5 never executes. BEQ with unequal operands at pc 4 -> next fetch 5.
- r3 = 20; JALR r4,r3 at pc 9 -> r4 = 0x000A, next fetch 20. BEQ with simm = -1 at pc 0 and PC_W = 8 -> pc = 0 (self-loop); BEQ at pc 255 with simm = 0 -> wraps to 0.
- HALT (JALR r0,r0 with imm 1) -> halted = 1, no further imem_req, registers unchanged for 100 cycles.
- rst_n pulled low while dmem_req is high and ack is pending -> req drops immediately; after release, pc = RESET_PC and all registers are 0.
